// File: rtl/navre_io_harness.sv
// IO-space responder and test monitor for softusb_navre: answers IO reads, traces every access, flags end of test.
// Latency: io_di one cycle after io_re; a trace entry is visible one cycle after its strobe; no pass-through.
// Backpressure: trace drains on valid/ready, a full FIFO drops the entry and sets sticky overflow.
// NAVRE_IO_WATCHDOG_EN builds the cycle counter/timeout; without it cycles and timeout read 0.

module navre_io_fifo #(
    parameter int W         = 15,
    parameter int LOG_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);
    localparam int                 DEPTH    = 2 ** LOG_DEPTH;
    localparam logic [LOG_DEPTH:0] FULL_CNT = DEPTH[LOG_DEPTH:0];

    logic [W-1:0]         mem_q [DEPTH];
    logic [W-1:0]         mem_d [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LOG_DEPTH:0]   count_q, count_d;
    logic                 push, pop;

    always_comb begin
        out_vld  = (count_q != '0);
        out_dat  = mem_q[rd_ptr_q];
        pop      = out_vld && out_rdy;
        // a pop in the same cycle frees the slot the push needs
        in_rdy   = (count_q != FULL_CNT) || pop;
        push     = in_vld && in_rdy;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

module navre_io_harness #(
    parameter int            AW          = 6,
    parameter int            DW          = 8,
    parameter int            READ_MODE   = 0,
    parameter logic [AW-1:0] FF_ADDR0    = AW'('h11),
    parameter logic [AW-1:0] FF_ADDR1    = AW'('h12),
    parameter logic [AW-1:0] END_ADDR    = AW'('h00),
    parameter logic [DW-1:0] END_DATA    = DW'('hFE),
    parameter int            LOG_DEPTH   = 4,
    parameter int            CYCLE_LIMIT = 10000,
    parameter int            CW          = 16
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          io_re,
    input  logic          io_we,
    input  logic [AW-1:0] io_a,
    input  logic [DW-1:0] io_do,
    output logic [DW-1:0] io_di,
    output logic          trace_valid,
    input  logic          trace_ready,
    output logic          trace_we,
    output logic [AW-1:0] trace_a,
    output logic [DW-1:0] trace_d,
    output logic          trace_overflow,
    output logic          end_of_test,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycles
);
    logic [DW-1:0]    base_dat, rd_dat;
    logic [DW-1:0]    io_di_q, io_di_d;
    logic             overflow_q, overflow_d, eot_q, eot_d, done_q, done_d;
    logic             eot_match, push_vld, push_rdy;
    logic [AW+DW:0]   push_dat, head_dat;

    generate
        if (READ_MODE == 1) begin : g_regfile
            logic [DW-1:0] regfile_q [2**AW];
            logic [DW-1:0] regfile_d [2**AW];
            always_comb begin
                regfile_d = regfile_q;
                if (io_we) regfile_d[io_a] = io_do;
            end
            always_ff @(posedge sys_clk) begin
                if (!sys_rst_n) regfile_q <= '{default: '0};
                else            regfile_q <= regfile_d;
            end
            // old contents are returned when a write hits the same address
            assign base_dat = regfile_q[io_a];
        end else begin : g_echo
            assign base_dat = DW'(io_a);
        end
    endgenerate

    always_comb begin
        rd_dat     = ((io_a == FF_ADDR0) || (io_a == FF_ADDR1)) ? '1 : base_dat;
        io_di_d    = io_re ? rd_dat : io_di_q;
        eot_match  = io_we && (io_a == END_ADDR) && (io_do == END_DATA);
        eot_d      = eot_match;
        done_d     = done_q || eot_match;
        push_vld   = io_we || io_re;
        push_dat   = {io_we, io_a, io_we ? io_do : rd_dat};
        overflow_d = overflow_q || (push_vld && !push_rdy);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            io_di_q    <= '0;
            overflow_q <= 1'b0;
            eot_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            io_di_q    <= io_di_d;
            overflow_q <= overflow_d;
            eot_q      <= eot_d;
            done_q     <= done_d;
        end
    end

    navre_io_fifo #(.W(AW + DW + 1), .LOG_DEPTH(LOG_DEPTH)) u_trace_fifo (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .in_vld  (push_vld),
        .in_rdy  (push_rdy),
        .in_dat  (push_dat),
        .out_vld (trace_valid),
        .out_rdy (trace_ready),
        .out_dat (head_dat)
    );

    assign io_di          = io_di_q;
    assign trace_we       = head_dat[AW+DW];
    assign trace_a        = head_dat[AW+DW-1:DW];
    assign trace_d        = head_dat[DW-1:0];
    assign trace_overflow = overflow_q;
    assign end_of_test    = eot_q;
    assign done           = done_q;

`ifdef NAVRE_IO_WATCHDOG_EN
    logic [CW-1:0] cycles_q, cycles_d;
    logic          timeout_q, timeout_d;

    always_comb begin
        cycles_d  = cycles_q;
        timeout_d = timeout_q;
        // counting stops once either flag is up, so cycles freezes at the limit
        if (!done_q && !timeout_q) begin
            cycles_d = cycles_q + 1'b1;
            if (cycles_d == CW'(CYCLE_LIMIT)) timeout_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cycles_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            cycles_q  <= cycles_d;
            timeout_q <= timeout_d;
        end
    end

    assign cycles  = cycles_q;
    assign timeout = timeout_q;
`else
    assign cycles  = '0;
    assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_navre_io_harness.sv
// Directed bench: u_dut0 uses defaults (echo mode, depth 16); u_dut1 is register-file mode, depth 4, limit 100.
`timescale 1ns/1ps
module tb_navre_io_harness;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        rst0_n, re0, we0, rdy0, tv0, twe0, tov0, eot0, done0, tmo0;
    logic [5:0]  a0, ta0;
    logic [7:0]  do0, di0, td0;
    logic [15:0] cyc0;
    logic        rst1_n, re1, we1, rdy1, tv1, twe1, tov1, eot1, done1, tmo1;
    logic [5:0]  a1, ta1;
    logic [7:0]  do1, di1, td1;
    logic [15:0] cyc1;

    navre_io_harness u_dut0 (
        .sys_clk(clk), .sys_rst_n(rst0_n), .io_re(re0), .io_we(we0), .io_a(a0), .io_do(do0),
        .io_di(di0), .trace_valid(tv0), .trace_ready(rdy0), .trace_we(twe0), .trace_a(ta0),
        .trace_d(td0), .trace_overflow(tov0), .end_of_test(eot0), .done(done0),
        .timeout(tmo0), .cycles(cyc0)
    );

    navre_io_harness #(.READ_MODE(1), .LOG_DEPTH(2), .CYCLE_LIMIT(100)) u_dut1 (
        .sys_clk(clk), .sys_rst_n(rst1_n), .io_re(re1), .io_we(we1), .io_a(a1), .io_do(do1),
        .io_di(di1), .trace_valid(tv1), .trace_ready(rdy1), .trace_we(twe1), .trace_a(ta1),
        .trace_d(td1), .trace_overflow(tov1), .end_of_test(eot1), .done(done1),
        .timeout(tmo1), .cycles(cyc1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst0_n = 1'b0; re0 = 1'b1; we0 = 1'b1; a0 = 6'h00; do0 = 8'hFE; rdy0 = 1'b1;
        rst1_n = 1'b0; re1 = 1'b1; we1 = 1'b1; a1 = 6'h00; do1 = 8'hFE; rdy1 = 1'b1;
        tick(); tick();
        checks++;
        if ({di0, tv0, twe0, ta0, td0, tov0, eot0, done0, tmo0, cyc0} !== '0) begin
            errors++;
            $display("FAIL reset_dut0: di=%h v=%b a=%h d=%h ovf=%b eot=%b done=%b tmo=%b cyc=%0d, all must be 0",
                     di0, tv0, ta0, td0, tov0, eot0, done0, tmo0, cyc0);
        end
        checks++;
        if ({di1, tv1, twe1, ta1, td1, tov1, eot1, done1, tmo1, cyc1} !== '0) begin
            errors++;
            $display("FAIL reset_dut1: di=%h v=%b a=%h d=%h ovf=%b eot=%b done=%b tmo=%b cyc=%0d, all must be 0",
                     di1, tv1, ta1, td1, tov1, eot1, done1, tmo1, cyc1);
        end
        re0 = 1'b0; we0 = 1'b0; rdy0 = 1'b0; rst0_n = 1'b1;
        re1 = 1'b0; we1 = 1'b0; rdy1 = 1'b0; rst1_n = 1'b1;
        tick();
        checks++;
        if ({tv0, eot0, done0, tv1, eot1, done1} !== 6'b0) begin
            errors++;
            $display("FAIL reset_strobes_ignored: v0=%b eot0=%b done0=%b v1=%b eot1=%b done1=%b, expected all 0",
                     tv0, eot0, done0, tv1, eot1, done1);
        end
    endtask

    task automatic test_mode0_read();
        logic [5:0]  adr [3];
        logic [7:0]  exp_di [3];
        logic [14:0] exp [3];
        adr[0] = 6'h05; adr[1] = 6'h11; adr[2] = 6'h12;
        exp_di[0] = 8'h05; exp_di[1] = 8'hFF; exp_di[2] = 8'hFF;
        exp[0] = {1'b0, 6'h05, 8'h05}; exp[1] = {1'b0, 6'h11, 8'hFF}; exp[2] = {1'b0, 6'h12, 8'hFF};
        for (int i = 0; i < 3; i++) begin
            re0 = 1'b1; a0 = adr[i];
            tick();
            checks++;
            if (di0 !== exp_di[i]) begin
                errors++;
                $display("FAIL m0_read[%0d]: io_di=%h expected %h", i, di0, exp_di[i]);
            end
            if (i == 0) begin
                checks++;
                if (tv0 !== 1'b1) begin
                    errors++;
                    $display("FAIL m0_trace_latency: trace_valid=%b expected 1", tv0);
                end
            end
        end
        re0 = 1'b0; a0 = 6'h05;
        tick();
        checks++;
        if (di0 !== 8'hFF) begin
            errors++;
            $display("FAIL m0_hold: io_di=%h expected ff", di0);
        end
        checks++;
        if ({tv0, twe0, ta0, td0} !== {1'b1, exp[0]}) begin
            errors++;
            $display("FAIL m0_head_stable: v=%b we=%b a=%h d=%h expected entry %h", tv0, twe0, ta0, td0, exp[0]);
        end
        rdy0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({tv0, twe0, ta0, td0} !== {1'b1, exp[i]}) begin
                errors++;
                $display("FAIL m0_trace[%0d]: v=%b we=%b a=%h d=%h expected entry %h", i, tv0, twe0, ta0, td0, exp[i]);
            end
            tick();
        end
        rdy0 = 1'b0;
        checks++;
        if (tv0 !== 1'b0) begin
            errors++;
            $display("FAIL m0_trace_empty: trace_valid=%b expected 0", tv0);
        end
    endtask

    task automatic test_mode1_rw();
        logic [14:0] exp [4];
        exp[0] = {1'b1, 6'h07, 8'h3C}; exp[1] = {1'b0, 6'h07, 8'h3C};
        exp[2] = {1'b1, 6'h07, 8'h5A}; exp[3] = {1'b0, 6'h07, 8'h5A};
        we1 = 1'b1; a1 = 6'h07; do1 = 8'h3C;
        tick();
        we1 = 1'b0; re1 = 1'b1;
        tick();
        checks++;
        if (di1 !== 8'h3C) begin
            errors++;
            $display("FAIL m1_read_after_write: io_di=%h expected 3c", di1);
        end
        we1 = 1'b1; do1 = 8'h5A;
        tick();
        checks++;
        if (di1 !== 8'h3C) begin
            errors++;
            $display("FAIL m1_read_before_write: io_di=%h expected 3c", di1);
        end
        we1 = 1'b0;
        tick();
        checks++;
        if (di1 !== 8'h5A) begin
            errors++;
            $display("FAIL m1_read_new: io_di=%h expected 5a", di1);
        end
        re1 = 1'b0;
        rdy1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({tv1, twe1, ta1, td1} !== {1'b1, exp[i]}) begin
                errors++;
                $display("FAIL m1_trace[%0d]: v=%b we=%b a=%h d=%h expected entry %h", i, tv1, twe1, ta1, td1, exp[i]);
            end
            tick();
        end
        rdy1 = 1'b0;
        checks++;
        if ({tv1, tov1} !== 2'b00) begin
            errors++;
            $display("FAIL m1_trace_end: valid=%b overflow=%b expected 0 0", tv1, tov1);
        end
    endtask

    task automatic test_overflow();
        rdy1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            we1 = 1'b1; a1 = 6'(i); do1 = 8'h10 + 8'(i);
            tick();
            if (i == 3) begin
                checks++;
                if (tov1 !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_exact_full: overflow=%b expected 0", tov1);
                end
            end
        end
        we1 = 1'b0;
        tick();
        checks++;
        if (tov1 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag: overflow=%b expected 1", tov1);
        end
        rdy1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({tv1, twe1, ta1, td1} !== {1'b1, 1'b1, 6'(i), 8'h10 + 8'(i)}) begin
                errors++;
                $display("FAIL ovf_drain[%0d]: v=%b we=%b a=%h d=%h expected a=%h d=%h", i, tv1, twe1, ta1, td1, 6'(i), 8'h10 + 8'(i));
            end
            tick();
        end
        rdy1 = 1'b0;
        checks++;
        if ({tv1, tov1} !== 2'b01) begin
            errors++;
            $display("FAIL ovf_after_drain: valid=%b overflow=%b expected 0 1", tv1, tov1);
        end
    endtask

    task automatic test_full_push_pop();
        rst1_n = 1'b0;
        tick();
        rst1_n = 1'b1;
        checks++;
        if (tov1 !== 1'b0) begin
            errors++;
            $display("FAIL fpp_reset_ovf: overflow=%b expected 0", tov1);
        end
        for (int i = 0; i < 4; i++) begin
            we1 = 1'b1; a1 = 6'h20 + 6'(i); do1 = 8'hA0 + 8'(i);
            tick();
        end
        rdy1 = 1'b1; a1 = 6'h24; do1 = 8'hA4;
        tick();
        rdy1 = 1'b0;
        checks++;
        if (tov1 !== 1'b0) begin
            errors++;
            $display("FAIL fpp_no_drop: overflow=%b expected 0", tov1);
        end
        a1 = 6'h25; do1 = 8'hA5;
        tick();
        we1 = 1'b0;
        checks++;
        if (tov1 !== 1'b1) begin
            errors++;
            $display("FAIL fpp_still_full: overflow=%b expected 1", tov1);
        end
        rdy1 = 1'b1;
        for (int i = 1; i < 5; i++) begin
            checks++;
            if ({tv1, twe1, ta1, td1} !== {1'b1, 1'b1, 6'h20 + 6'(i), 8'hA0 + 8'(i)}) begin
                errors++;
                $display("FAIL fpp_drain[%0d]: v=%b we=%b a=%h d=%h expected a=%h d=%h", i, tv1, twe1, ta1, td1, 6'h20 + 6'(i), 8'hA0 + 8'(i));
            end
            tick();
        end
        rdy1 = 1'b0;
        checks++;
        if (tv1 !== 1'b0) begin
            errors++;
            $display("FAIL fpp_empty: trace_valid=%b expected 0", tv1);
        end
    endtask

    task automatic test_mid_reset();
        rdy1 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            we1 = 1'b1; a1 = 6'h30 + 6'(i); do1 = 8'h11;
            tick();
        end
        rst1_n = 1'b0; a1 = 6'h07; do1 = 8'h77;
        tick();
        checks++;
        if ({tv1, twe1, ta1, td1, tov1, di1} !== '0) begin
            errors++;
            $display("FAIL midrst_clear: v=%b we=%b a=%h d=%h ovf=%b di=%h expected all 0", tv1, twe1, ta1, td1, tov1, di1);
        end
        rst1_n = 1'b1; we1 = 1'b0; re1 = 1'b1; a1 = 6'h07;
        tick();
        re1 = 1'b0;
        checks++;
        if (di1 !== 8'h00) begin
            errors++;
            $display("FAIL midrst_regfile: io_di=%h expected 00", di1);
        end
        checks++;
        if ({tv1, twe1, ta1, td1} !== {1'b1, 1'b0, 6'h07, 8'h00}) begin
            errors++;
            $display("FAIL midrst_trace: v=%b we=%b a=%h d=%h expected only the post-reset read", tv1, twe1, ta1, td1);
        end
        rdy1 = 1'b1;
        tick();
        rdy1 = 1'b0;
    endtask

    task automatic test_end_of_test();
        rst0_n = 1'b0;
        tick();
        rst0_n = 1'b1;
        repeat (9) tick();
        we0 = 1'b1; a0 = 6'h01; do0 = 8'hFE;
        tick();
        we0 = 1'b0;
        checks++;
        if ({eot0, done0} !== 2'b00) begin
            errors++;
            $display("FAIL eot_wrong_addr: eot=%b done=%b expected 0 0", eot0, done0);
        end
        repeat (39) tick();
`ifdef NAVRE_IO_WATCHDOG_EN
        checks++;
        if (cyc0 !== 16'd49) begin
            errors++;
            $display("FAIL eot_cycles_before: cycles=%0d expected 49", cyc0);
        end
`endif
        we0 = 1'b1; a0 = 6'h00; do0 = 8'hFE;
        tick();
        we0 = 1'b0;
        checks++;
        if ({eot0, done0} !== 2'b11) begin
            errors++;
            $display("FAIL eot_pulse: eot=%b done=%b expected 1 1", eot0, done0);
        end
        tick(); tick();
        checks++;
        if ({eot0, done0} !== 2'b01) begin
            errors++;
            $display("FAIL eot_one_cycle: eot=%b done=%b expected 0 1", eot0, done0);
        end
`ifdef NAVRE_IO_WATCHDOG_EN
        checks++;
        if ({cyc0, tmo0} !== {16'd50, 1'b0}) begin
            errors++;
            $display("FAIL eot_cycles_frozen: cycles=%0d timeout=%b expected 50 0", cyc0, tmo0);
        end
`endif
        we0 = 1'b1;
        tick();
        we0 = 1'b0;
        checks++;
        if ({eot0, done0} !== 2'b11) begin
            errors++;
            $display("FAIL eot_repeat: eot=%b done=%b expected 1 1", eot0, done0);
        end
        rdy0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({tv0, twe0, ta0, td0} !== {1'b1, 1'b1, (i == 0) ? 6'h01 : 6'h00, 8'hFE}) begin
                errors++;
                $display("FAIL eot_trace[%0d]: v=%b we=%b a=%h d=%h expected a=%h d=fe", i, tv0, twe0, ta0, td0, (i == 0) ? 6'h01 : 6'h00);
            end
            tick();
        end
        rdy0 = 1'b0;
    endtask

    task automatic test_watchdog();
`ifdef NAVRE_IO_WATCHDOG_EN
        rst1_n = 1'b0;
        tick();
        rst1_n = 1'b1;
        repeat (99) tick();
        checks++;
        if ({cyc1, tmo1} !== {16'd99, 1'b0}) begin
            errors++;
            $display("FAIL wd_before_limit: cycles=%0d timeout=%b expected 99 0", cyc1, tmo1);
        end
        tick();
        checks++;
        if ({cyc1, tmo1} !== {16'd100, 1'b1}) begin
            errors++;
            $display("FAIL wd_at_limit: cycles=%0d timeout=%b expected 100 1", cyc1, tmo1);
        end
        repeat (5) tick();
        checks++;
        if ({cyc1, tmo1} !== {16'd100, 1'b1}) begin
            errors++;
            $display("FAIL wd_sticky: cycles=%0d timeout=%b expected 100 1", cyc1, tmo1);
        end
        rst1_n = 1'b0;
        tick();
        rst1_n = 1'b1;
        checks++;
        if ({cyc1, tmo1, done1, eot1, tov1} !== '0) begin
            errors++;
            $display("FAIL wd_reset: cycles=%0d timeout=%b done=%b eot=%b ovf=%b expected all 0", cyc1, tmo1, done1, eot1, tov1);
        end
        repeat (99) tick();
        we1 = 1'b1; a1 = 6'h00; do1 = 8'hFE;
        tick();
        we1 = 1'b0;
        checks++;
        if ({cyc1, tmo1, done1, eot1} !== {16'd100, 3'b111}) begin
            errors++;
            $display("FAIL wd_same_edge: cycles=%0d timeout=%b done=%b eot=%b expected 100 1 1 1", cyc1, tmo1, done1, eot1);
        end
`else
        repeat (120) tick();
        checks++;
        if ({cyc1, tmo1, cyc0, tmo0} !== '0) begin
            errors++;
            $display("FAIL wd_disabled: cycles1=%0d timeout1=%b cycles0=%0d timeout0=%b expected all 0", cyc1, tmo1, cyc0, tmo0);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_mode0_read();
        test_mode1_rw();
        test_overflow();
        test_full_push_pop();
        test_mid_reset();
        test_end_of_test();
        test_watchdog();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
